// File: rtl/seg_scan_reader.sv
// Passive reader for a multiplexed 4-digit seven-segment bus: captures settled
// digits, assembles frames and reports the signed value once a frame is stable.
module seg_scan_reader #(
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned STABLE_FRAMES  = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [0:6]  seg,
    input  logic [3:0]  an,
    output logic [15:0] digits,
    output logic [15:0] value,
    output logic        frame_valid,
    output logic        frame_error,
    output logic        stale
);
    localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned MW = $clog2(STABLE_FRAMES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {S_WAIT, S_SETTLE, S_HOLD} state_t;

    state_t          state;
    logic [0:6]      seg_r, seg_p;
    logic [3:0]      an_r, an_p;
    logic [SW-1:0]   cnt;
    logic [15:0]     slot_codes;
    logic [3:0]      slot_bad;
    logic [3:0]      mask;
    logic [15:0]     prev_frame;
    logic            prev_valid;
    logic [MW-1:0]   match;
    logic [TW-1:0]   tcnt;

    logic            an_ok, changed, capture, complete, same, accept;
    logic [1:0]      idx;
    logic [3:0]      code;
    logic            bad;
    logic            fmt_ok, seen, has_digit, neg;
    logic [3:0]      c;
    logic [13:0]     mag;
    logic [15:0]     frame_value;

    always_comb begin
        an_ok   = $onehot(~an_r);
        changed = (an_r != an_p) || (seg_r != seg_p);
        capture = (state == S_SETTLE) && !changed && (cnt == SW'(SETTLE_CYCLES));
        case (an_r)
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
    end

    always_comb begin
        bad  = 1'b0;
        code = 4'hF;
        case (seg_r)
            7'b0000001: code = 4'd0;
            7'b1001111: code = 4'd1;
            7'b0010010: code = 4'd2;
            7'b0000110: code = 4'd3;
            7'b1001100: code = 4'd4;
            7'b0100100: code = 4'd5;
            7'b0100000: code = 4'd6;
            7'b0001111: code = 4'd7;
            7'b0000000: code = 4'd8;
            7'b0000100: code = 4'd9;
            7'b1111110: code = 4'hE;
            7'b1111111: code = 4'hF;
            default:    bad  = 1'b1;
        endcase
    end

    // Scan left to right: blanks only before the first non-blank, minus only as
    // that first non-blank; Horner accumulation gives sum of d_i * 10^i.
    always_comb begin
        fmt_ok    = (slot_bad == 4'b0000);
        seen      = 1'b0;
        has_digit = 1'b0;
        neg       = 1'b0;
        mag       = '0;
        c         = '0;
        for (int unsigned j = 0; j < 4; j++) begin
            c = slot_codes[4'(12 - 4 * j) +: 4];
            if (c == 4'hF) begin
                if (seen) fmt_ok = 1'b0;
            end else begin
                if (c == 4'hE) begin
                    if (seen) fmt_ok = 1'b0;
                    neg = 1'b1;
                end else begin
                    has_digit = 1'b1;
                end
                seen = 1'b1;
            end
            mag = mag * 14'd10 + {10'd0, (c <= 4'd9) ? c : 4'd0};
        end
        if (!has_digit) fmt_ok = 1'b0;
        frame_value = {2'b00, mag};
        if (neg) frame_value = -frame_value;
        complete = (mask == 4'b1111);
        same     = prev_valid && (slot_codes == prev_frame);
        accept   = complete && fmt_ok &&
                   (same ? (match == MW'(STABLE_FRAMES - 1)) : (STABLE_FRAMES == 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_WAIT;
            seg_r       <= '1;
            seg_p       <= '1;
            an_r        <= '1;
            an_p        <= '1;
            cnt         <= '0;
            slot_codes  <= '1;
            slot_bad    <= '0;
            mask        <= '0;
            prev_frame  <= '1;
            prev_valid  <= 1'b0;
            match       <= '0;
            digits      <= 16'hFFFF;
            value       <= '0;
            frame_valid <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            seg_r       <= seg;
            seg_p       <= seg_r;
            an_r        <= an;
            an_p        <= an_r;
            frame_valid <= 1'b0;
            frame_error <= 1'b0;

            case (state)
                S_WAIT: begin
                    if (an_ok) begin
                        state <= S_SETTLE;
                        cnt   <= SW'(1);
                    end
                end
                S_SETTLE: begin
                    if (changed) begin
                        state <= S_WAIT;
                    end else if (capture) begin
                        slot_codes[{idx, 2'b00} +: 4] <= code;
                        slot_bad[idx]                 <= bad;
                        state                         <= S_HOLD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (an_r != an_p) state <= S_WAIT;
                end
                default: state <= S_WAIT;
            endcase

            // A capture landing on the completion cycle starts the next mask.
            if (complete) mask <= capture ? ~an_r : 4'b0000;
            else if (capture) mask <= mask | ~an_r;

            if (complete) begin
                if (!fmt_ok) begin
                    frame_error <= 1'b1;
                    match       <= '0;
                    prev_valid  <= 1'b0;
                end else if (same) begin
                    if (match != MW'(STABLE_FRAMES)) match <= match + 1'b1;
                end else begin
                    prev_frame <= slot_codes;
                    prev_valid <= 1'b1;
                    match      <= MW'(1);
                end
            end
            if (accept) begin
                digits      <= slot_codes;
                value       <= frame_value;
                frame_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || accept) begin
            tcnt  <= '0;
            stale <= 1'b0;
        end else if (tcnt != TW'(TIMEOUT_CYCLES)) begin
            tcnt <= tcnt + 1'b1;
            if (tcnt == TW'(TIMEOUT_CYCLES - 1)) stale <= 1'b1;
        end
    end
endmodule
